fifo_rd_packer: RTL and testbench

Read-side drain stage for the dual-clock FIFO, in the `rclk` domain. It pops words through the FIFO's `rinc`/`rempty`/`rdata` read port and packs `PACK` consecutive words into one wide beat. It presents each beat on a valid/ready stream toward the consumer. A flush request emits a partial beat carrying a word count.

---
 rtl/fifo_rd_pkg.sv | 15 +
 rtl/fifo_rd_packer.sv | 145 ++++++++++++++
 tb/tb_fifo_rd_packer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side packer: count-width derivation
// and the default packed-beat type.
package fifo_rd_pkg;

    localparam int DSIZE_DEF = 32'd8;
    localparam int PACK_DEF  = 32'd4;

    // Width needed to hold a word count in the range 0..pack.
    function automatic int cntw_f(input int pack);
        return $clog2(pack + 32'd1);
    endfunction

    typedef logic [PACK_DEF-1:0][DSIZE_DEF-1:0] beat_t;

endpackage

// File: rtl/fifo_rd_packer.sv
// Read-domain drain stage: pops FIFO words, packs PACK of them into one wide
// beat and presents it on a valid/ready stream; flush emits a partial beat.
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int  DSIZE = 32'd8,
    parameter int  PACK  = 32'd4,
    localparam int CNTW  = cntw_f(PACK)
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    input  logic [DSIZE-1:0]      rdata,
    output logic                  rinc,
    input  logic                  flush,
    output logic                  flush_busy,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DSIZE*PACK-1:0] m_data,
    output logic [CNTW-1:0]       m_words
);

    typedef logic [PACK-1:0][DSIZE-1:0] slots_t;

    localparam logic [CNTW-1:0] CNT_ZERO  = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(32'd1);
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(PACK - 32'd1);
    localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(PACK);
    localparam logic [CNTW:0]   FILL_FULL = (CNTW + 1)'(PACK);

    logic [CNTW-1:0] cnt_r;
    logic            infl_r;
    logic            fpend_r;
    slots_t          pack_r;
    logic            m_valid_r;
    slots_t          m_data_r;
    logic [CNTW-1:0] m_words_r;

    logic            out_free_s;
    logic [CNTW:0]   fill_s;
    logic [CNTW-1:0] cnt_nxt_s;
    logic            fpend_nxt_s;
    slots_t          pack_nxt_s;
    logic            load_s;
    slots_t          load_data_s;
    logic [CNTW-1:0] load_words_s;

    // A word in flight counts against capacity; the last slot may only be
    // requested when the output register can take the finished beat.
    assign out_free_s = !m_valid_r || m_ready;
    assign fill_s     = {1'b0, cnt_r} + {{CNTW{1'b0}}, infl_r};
    assign rinc       = rrst_n && !rempty && !fpend_r &&
                        ((fill_s < FILL_FULL) || ((fill_s == FILL_FULL) && out_free_s));

    // Next-state for the pack register, word count, flush flag and output load.
    always_comb begin
        pack_nxt_s   = pack_r;
        cnt_nxt_s    = cnt_r;
        fpend_nxt_s  = fpend_r || flush;
        load_s       = 1'b0;
        load_data_s  = pack_r;
        load_words_s = cnt_r;
        if (infl_r) begin
            for (int i = 0; i < PACK; i++) begin
                if (cnt_r == CNTW'(i)) begin
                    pack_nxt_s[i] = rdata;
                end else begin
                    pack_nxt_s[i] = pack_r[i];
                end
            end
            if ((cnt_r == CNT_LAST) && out_free_s) begin
                load_s       = 1'b1;
                load_data_s  = pack_nxt_s;
                load_words_s = CNT_FULL;
                cnt_nxt_s    = CNT_ZERO;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else if (cnt_r == CNT_FULL) begin
            if (out_free_s) begin
                load_s       = 1'b1;
                load_data_s  = pack_r;
                load_words_s = CNT_FULL;
                cnt_nxt_s    = CNT_ZERO;
                fpend_nxt_s  = fpend_r ? 1'b0 : flush;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else if (fpend_r) begin
            if (cnt_r == CNT_ZERO) begin
                fpend_nxt_s = 1'b0;
            end else if (out_free_s) begin
                load_s       = 1'b1;
                load_words_s = cnt_r;
                cnt_nxt_s    = CNT_ZERO;
                fpend_nxt_s  = 1'b0;
                for (int i = 0; i < PACK; i++) begin
                    load_data_s[i] = (CNTW'(i) < cnt_r) ? pack_r[i] : {DSIZE{1'b0}};
                end
            end else begin
                fpend_nxt_s = 1'b1;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Pack register, word count, in-flight and flush-pending state.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pack_r  <= {(DSIZE*PACK){1'b0}};
            cnt_r   <= CNT_ZERO;
            infl_r  <= 1'b0;
            fpend_r <= 1'b0;
        end else begin
            pack_r  <= pack_nxt_s;
            cnt_r   <= cnt_nxt_s;
            infl_r  <= rinc;
            fpend_r <= fpend_nxt_s;
        end
    end

    // Output beat register; a new load wins over the consumer draining it.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_valid_r <= 1'b0;
            m_data_r  <= {(DSIZE*PACK){1'b0}};
            m_words_r <= CNT_ZERO;
        end else if (load_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= load_data_s;
            m_words_r <= load_words_s;
        end else if (m_ready) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    assign m_valid    = m_valid_r;
    assign m_data     = m_data_r;
    assign m_words    = m_words_r;
    assign flush_busy = fpend_r;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a queue models the FIFO read port and
// expected beats are queued as words are supplied.
module tb_fifo_rd_packer;

    logic        rclk = 1'b0;
    logic        rrst_n;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic        flush;
    logic        flush_busy;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [2:0]  m_words;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  words;
    } exp_beat_t;

    exp_beat_t  exp_q[$];
    logic [7:0] fifo_q[$];
    int         acc_cyc_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rinc_cnt = 0;
    int         last_rinc_cyc = -1;

    fifo_rd_packer #(.DSIZE(8), .PACK(4)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .flush_busy(flush_busy), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_words(m_words)
    );

    always #5 rclk = ~rclk;

    // One clock cycle: sample pops and accepted beats, then model the FIFO pop.
    task automatic tick();
        exp_beat_t e;
        logic      rinc_seen;
        #1;
        rinc_seen = rinc;
        if (rinc) begin
            rinc_cnt++;
            last_rinc_cyc = cyc;
            n_checks++;
            if (fifo_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_empty: rinc=1 with FIFO empty at cycle %0d, required 0", cyc);
            end
        end
        if (m_valid && m_ready) begin
            acc_cyc_q.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got data=%h words=%0d, required no beat", m_data, m_words);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e.data || m_words !== e.words) begin
                    n_fail++;
                    $display("FAIL beat: got data=%h words=%0d, required data=%h words=%0d",
                             m_data, m_words, e.data, e.words);
                end
            end
        end
        @(posedge rclk);
        #1;
        if (rinc_seen && fifo_q.size() > 0) rdata = fifo_q.pop_front();
        rempty = (fifo_q.size() == 0);
        cyc++;
        @(negedge rclk);
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        rempty = 1'b0;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [2:0] n);
        exp_beat_t e;
        e.data  = d;
        e.words = n;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) push_word(8'((i + 1) * 17));
        expect_beat(32'h44332211, 3'd4);
        tick();
        tick();
        n_checks++;
        if (rinc !== 1'b0 || m_valid !== 1'b0 || m_data !== 32'h0 || m_words !== 3'd0 || flush_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rinc=%b m_valid=%b m_data=%h m_words=%0d busy=%b, required all 0",
                     rinc, m_valid, m_data, m_words, flush_busy);
        end
    endtask

    task automatic test_basic_pack();
        int r0;
        int vcyc;
        r0   = rinc_cnt;
        vcyc = -1;
        rrst_n = 1'b1;
        #1;
        n_checks++;
        if (rinc !== 1'b1) begin
            n_fail++;
            $display("FAIL rinc_after_reset: got %b, required 1", rinc);
        end
        for (int i = 0; i < 20 && vcyc < 0; i++) begin
            tick();
            if (m_valid === 1'b1) vcyc = cyc;
        end
        n_checks++;
        if (vcyc < 0 || vcyc - last_rinc_cyc != 2 || rinc_cnt - r0 != 4) begin
            n_fail++;
            $display("FAIL basic_latency: valid at %0d last rinc %0d pops %0d, required valid 2 after, 4 pops",
                     vcyc, last_rinc_cyc, rinc_cnt - r0);
        end
        n_checks++;
        if (m_data !== 32'h44332211 || m_words !== 3'd4) begin
            n_fail++;
            $display("FAIL basic_data: got %h/%0d, required 44332211/4", m_data, m_words);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
    endtask

    task automatic test_throughput();
        int r0;
        int c0;
        acc_cyc_q.delete();
        r0 = rinc_cnt;
        c0 = cyc;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 4; i++) push_word(8'(b * 4 + i));
            expect_beat({8'(b * 4 + 3), 8'(b * 4 + 2), 8'(b * 4 + 1), 8'(b * 4)}, 3'd4);
        end
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        n_checks++;
        if (rinc_cnt - r0 != 16 || last_rinc_cyc - c0 != 15) begin
            n_fail++;
            $display("FAIL thru_rinc: pops %0d span %0d, required 16 pops over 15 cycles",
                     rinc_cnt - r0, last_rinc_cyc - c0);
        end
        n_checks++;
        if (acc_cyc_q.size() != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL thru_beats: got %0d beats (%0d pending), required 4", acc_cyc_q.size(), exp_q.size());
        end else begin
            n_checks++;
            if (acc_cyc_q[0] != c0 + 5) begin
                n_fail++;
                $display("FAIL thru_first: beat at cycle %0d, required %0d", acc_cyc_q[0], c0 + 5);
            end
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (acc_cyc_q[i] - acc_cyc_q[i-1] != 4) begin
                    n_fail++;
                    $display("FAIL thru_gap%0d: got %0d cycles, required 4", i, acc_cyc_q[i] - acc_cyc_q[i-1]);
                end
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int r0;
        int cr;
        acc_cyc_q.delete();
        m_ready = 1'b0;
        r0 = rinc_cnt;
        for (int i = 0; i < 12; i++) push_word(8'(i));
        expect_beat(32'h03020100, 3'd4);
        expect_beat(32'h07060504, 3'd4);
        expect_beat(32'h0B0A0908, 3'd4);
        repeat (30) tick();
        n_checks++;
        if (rinc_cnt - r0 != 8) begin
            n_fail++;
            $display("FAIL bp_pops: got %0d, required 8", rinc_cnt - r0);
        end
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h03020100 || m_words !== 3'd4) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b data=%h words=%0d, required 1/03020100/4", m_valid, m_data, m_words);
        end
        m_ready = 1'b1;
        cr = cyc;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        n_checks++;
        if (exp_q.size() != 0 || acc_cyc_q.size() != 3 || acc_cyc_q[0] != cr || rinc_cnt - r0 != 12) begin
            n_fail++;
            $display("FAIL bp_drain: pending %0d beats %0d pops %0d, required 0/3/12 and first at %0d",
                     exp_q.size(), acc_cyc_q.size(), rinc_cnt - r0, cr);
        end
        tick();
    endtask

    task automatic test_flush();
        int r0;
        r0 = rinc_cnt;
        push_word(8'hA1);
        push_word(8'hA2);
        repeat (5) tick();
        n_checks++;
        if (rinc_cnt - r0 != 2 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_setup: pops %0d valid %b, required 2/0", rinc_cnt - r0, m_valid);
        end
        expect_beat(32'h0000A2A1, 3'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (flush_busy !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pending: busy=%b valid=%b, required 1/0", flush_busy, m_valid);
        end
        tick();
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h0000A2A1 || m_words !== 3'd2 || flush_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_beat: valid=%b data=%h words=%0d busy=%b, required 1/0000a2a1/2/0",
                     m_valid, m_data, m_words, flush_busy);
        end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (flush_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_empty_busy: got %b, required 1", flush_busy);
        end
        tick();
        n_checks++;
        if (flush_busy !== 1'b0 || m_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL flush_empty_done: busy=%b valid=%b pending=%0d, required 0/0/0",
                     flush_busy, m_valid, exp_q.size());
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_beat();
        int r0;
        r0 = rinc_cnt;
        for (int i = 0; i < 3; i++) push_word(8'(8'h51 + i));
        repeat (5) tick();
        n_checks++;
        if (rinc_cnt - r0 != 3 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_setup: pops %0d valid %b, required 3/0", rinc_cnt - r0, m_valid);
        end
        rrst_n = 1'b0;
        tick();
        n_checks++;
        if (m_valid !== 1'b0 || rinc !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b rinc=%b, required 0/0", m_valid, rinc);
        end
        rrst_n = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'(8'h61 + i));
        expect_beat(32'h64636261, 3'd4);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        n_checks++;
        if (exp_q.size() != 0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_clean_beat: pending %0d valid %b, required 0/0", exp_q.size(), m_valid);
        end
    endtask

    initial begin
        rrst_n  = 1'b0;
        rempty  = 1'b1;
        rdata   = 8'h00;
        flush   = 1'b0;
        m_ready = 1'b1;
        @(negedge rclk);
        test_reset();
        test_basic_pack();
        test_throughput();
        test_backpressure();
        test_flush();
        test_reset_mid_beat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
